// File: rtl/thread_pkg.sv
// Shared types and constants for the hardware thread scheduler.
package thread_pkg;

  localparam int unsigned NUM_THREADS_DEF = 5;
  localparam int unsigned TID_W           = 3;
  localparam int unsigned MAX_THREADS     = 1 << TID_W;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_READY = 2'd1,
    T_WAIT  = 2'd2
  } thread_state_t;

  // One slot of the PC write-back delay line.
  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic             vld;
  } wb_entry_t;

  // Per-thread transition; halt dominates, and at most one of block/wake/start
  // is legal from any given state, so the remaining order only documents intent.
  function automatic thread_state_t next_thread_state(
    input thread_state_t cur,
    input logic          halt_hit,
    input logic          block_hit,
    input logic          wake_hit,
    input logic          start_hit
  );
    thread_state_t nxt;
    nxt = cur;
    if (halt_hit) begin
      nxt = T_IDLE;
    end else if (block_hit && (cur == T_READY)) begin
      nxt = T_WAIT;
    end else if (wake_hit && (cur == T_WAIT)) begin
      nxt = T_READY;
    end else if (start_hit && (cur == T_IDLE)) begin
      nxt = T_READY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first READY thread strictly after last_id, wrapping.
module rr_picker
  import thread_pkg::*;
#(
  parameter int unsigned NUM_THREADS = NUM_THREADS_DEF
) (
  input  logic [NUM_THREADS-1:0] ready_mask_i,
  input  logic [TID_W-1:0]       last_id_i,
  output logic [TID_W-1:0]       next_id_o,
  output logic                   found_o
);

  localparam int unsigned IDX_W = TID_W + 1;

  logic [MAX_THREADS-1:0] mask_full;

  // Zero-pad the mask so any TID_W-bit index is in range.
  assign mask_full = MAX_THREADS'(ready_mask_i);

  // Scan candidates last+1 .. last+NUM_THREADS (mod NUM_THREADS), keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    next_id_o = '0;
    found_o   = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      idx = {1'b0, last_id_i} + IDX_W'(k);
      if (idx >= IDX_W'(NUM_THREADS)) begin
        idx = idx - IDX_W'(NUM_THREADS);
      end
      if (!found_o && mask_full[idx[TID_W-1:0]]) begin
        found_o   = 1'b1;
        next_id_o = idx[TID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-style thread scheduler: per-thread state, round-robin PC read select
// and a delayed PC write-back select.
module thread_scheduler
  import thread_pkg::*;
#(
  parameter int unsigned NUM_THREADS = NUM_THREADS_DEF,
  parameter int unsigned WRITE_LAG   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   start,
  input  logic [TID_W-1:0]       start_id,
  input  logic                   halt,
  input  logic [TID_W-1:0]       halt_id,
  input  logic                   block,
  input  logic [TID_W-1:0]       block_id,
  input  logic                   wake,
  input  logic [TID_W-1:0]       wake_id,
  output logic [TID_W-1:0]       sel_read,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       sel_write,
  output logic                   pc_en,
  output logic [NUM_THREADS-1:0] ready_mask,
  output logic                   all_idle
);

  thread_state_t    state_q [NUM_THREADS];
  thread_state_t    state_d [NUM_THREADS];

  logic [TID_W-1:0] last_q, last_d;
  logic [TID_W-1:0] sel_read_q, sel_read_d;
  logic             issue_valid_q, issue_valid_d;
  logic             iss_vld_q, iss_vld_d;
  logic             pc_gate_q, pc_gate_d;
  wb_entry_t        wb_q [WRITE_LAG];
  wb_entry_t        wb_d [WRITE_LAG];

  logic [TID_W-1:0] pick_id;
  logic             pick_found;

  // Thread state next-state: events apply regardless of stall; ids out of range never match.
  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = next_thread_state(state_q[i],
                                     halt  && (halt_id  == TID_W'(i)),
                                     block && (block_id == TID_W'(i)),
                                     wake  && (wake_id  == TID_W'(i)),
                                     start && (start_id == TID_W'(i)));
    end
  end

  // Thread state registers; thread 0 comes out of reset ready to run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= (i == 0) ? T_READY : T_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Status views of the state registers.
  always_comb begin
    ready_mask = '0;
    all_idle   = 1'b1;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      ready_mask[i] = (state_q[i] == T_READY);
      if (state_q[i] != T_IDLE) begin
        all_idle = 1'b0;
      end
    end
  end

  rr_picker #(
    .NUM_THREADS (NUM_THREADS)
  ) u_picker (
    .ready_mask_i (ready_mask),
    .last_id_i    (last_q),
    .next_id_o    (pick_id),
    .found_o      (pick_found)
  );

  // Issue and write-back next-state; iss_vld_q remembers whether sel_read was a
  // real issue so a stall cannot drop its pending write-back.
  always_comb begin
    last_d        = last_q;
    sel_read_d    = sel_read_q;
    issue_valid_d = 1'b0;
    iss_vld_d     = iss_vld_q;
    pc_gate_d     = !stall;
    wb_d          = wb_q;
    if (!stall) begin
      issue_valid_d = pick_found;
      iss_vld_d     = pick_found;
      if (pick_found) begin
        sel_read_d = pick_id;
        last_d     = pick_id;
      end
      wb_d[0] = '{tid: sel_read_q, vld: iss_vld_q};
      for (int unsigned k = 1; k < WRITE_LAG; k++) begin
        wb_d[k] = wb_q[k-1];
      end
    end
  end

  // Issue and write-back registers; reset aborts in-flight write-backs at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q        <= TID_W'(NUM_THREADS - 1);
      sel_read_q    <= '0;
      issue_valid_q <= 1'b0;
      iss_vld_q     <= 1'b0;
      pc_gate_q     <= 1'b0;
      for (int unsigned k = 0; k < WRITE_LAG; k++) begin
        wb_q[k] <= '0;
      end
    end else begin
      last_q        <= last_d;
      sel_read_q    <= sel_read_d;
      issue_valid_q <= issue_valid_d;
      iss_vld_q     <= iss_vld_d;
      pc_gate_q     <= pc_gate_d;
      for (int unsigned k = 0; k < WRITE_LAG; k++) begin
        wb_q[k] <= wb_d[k];
      end
    end
  end

  assign sel_read    = sel_read_q;
  assign issue_valid = issue_valid_q;
  assign sel_write   = wb_q[WRITE_LAG-1].tid;
  assign pc_en       = wb_q[WRITE_LAG-1].vld & pc_gate_q;

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter NUM_THREADS, default 5, number of hardware threads (PC slots) scheduled; legal range 2..8.
REQ-002 Parameter WRITE_LAG, default 1, cycles from thread issue to its PC write-back select; legal range 1..3.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  freeze issue and write-back pipeline.
REQ-006 start, start_id  input  1, 3  make thread start_id READY.
REQ-007 halt, halt_id  input  1, 3  make thread halt_id IDLE.
REQ-008 block, block_id  input  1, 3  make thread block_id WAIT.
REQ-009 wake, wake_id  input  1, 3  move thread wake_id from WAIT to READY.
REQ-010 sel_read  output  3  thread whose PC is read (fetch) this cycle.
REQ-011 issue_valid  output  1  sel_read is a real issue this cycle.
REQ-012 sel_write  output  3  thread whose PC is written this cycle.
REQ-013 pc_en  output  1  PC write enable for sel_write.
REQ-014 ready_mask  output  NUM_THREADS  bit i = thread i READY (registered state).
REQ-015 all_idle  output  1  every thread IDLE.

Function
REQ-016 Per-thread state SHALL be one of T_IDLE, T_READY, T_WAIT, held in registers.
REQ-017 Transitions: start: IDLE->READY; halt: any->IDLE; block: READY->WAIT; wake: WAIT->READY; all others SHALL leave state unchanged.
REQ-018 Several events naming the same thread in one cycle SHALL resolve with priority halt > block > wake > start; events naming different threads SHALL all apply.
REQ-019 Events with id >= NUM_THREADS SHALL be ignored.
REQ-020 Event in cycle N SHALL update state at edge N->N+1 and first influence sel_read at edge N+1->N+2.
REQ-021 Each non-stalled edge SHALL register sel_read = first READY thread strictly after the last issued thread, modulo NUM_THREADS, and issue_valid=1.
REQ-022 A single READY thread SHALL be issued every cycle back-to-back.
REQ-023 No READY thread: issue_valid=0, sel_read and round-robin pointer hold.
REQ-024 stall=1: issue_valid=0, pc_en=0, sel_read, pointer and write pipeline hold; thread-state events still apply.
REQ-025 sel_write/pc_en SHALL equal sel_read/issue_valid delayed by WRITE_LAG non-stalled cycles; no squash on later halt/block.
REQ-026 ready_mask and all_idle SHALL reflect current state registers, no extra latency.

Reset
REQ-027 While reset=0: thread 0 READY, threads 1..NUM_THREADS-1 IDLE, pointer = NUM_THREADS-1.
REQ-028 While reset=0: sel_read=0, issue_valid=0, sel_write=0, pc_en=0, write pipeline cleared.
REQ-029 First edge after reset release SHALL issue thread 0 (issue_valid=1) unless stall=1.
REQ-030 Reset asserted mid-operation SHALL abort all in-flight write-backs immediately (pc_en=0 asynchronously).

Structure
REQ-031 Package thread_pkg SHALL hold NUM_THREADS default, TID_W=3 and enum thread_state_t {T_IDLE, T_READY, T_WAIT}.
REQ-032 Combinational sub-module rr_picker (ready mask + last id -> next id, found) SHALL implement REQ-021/023.
REQ-033 Write-back delay SHALL be a WRITE_LAG-deep shift register of {tid, valid} with hold on stall.

Verification
REQ-034 Reset release, no events -> sel_read 0,0,0,... issue_valid=1 from first edge; sel_write=0, pc_en=1 one cycle later.
REQ-035 start id 2 and 4 in cycle 1 -> from cycle 3 sel_read cycles 0,2,4,0,2,4; ready_mask=5'b10101.
REQ-036 Threads 0,1,2 READY, block id 1 then wake id 1 three cycles later -> sequence 0,2,0,2 then 1 rejoins in round-robin order; ready_mask bit1 low while WAIT.
REQ-037 halt and start same id 3 same cycle -> thread 3 IDLE; start id 7 -> ignored; halt all threads -> issue_valid=0, all_idle=1, sel_read holds.
REQ-038 stall high 4 cycles during 0,2,4 rotation -> issue_valid=0, pc_en=0, sel_read/sel_write frozen; rotation resumes with next thread after last issued.
REQ-039 reset pulled low mid-rotation with pc_en=1 -> pc_en=0 and outputs at reset values without waiting for clk.
